// File: rtl/apb_mem_slave_p_if.sv
// APB3 bus bundle between the decoder-side master and apb_mem_slave_p.
// The slave modport sees the request signals as inputs and drives the completion signals.
interface apb_mem_slave_p_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic                    PREADY;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB3 word-organised RAM slave with byte strobes and programmable wait states.
// Define APB_SLV_ERR_EN to flag out-of-range or misaligned accesses with PSLVERR; otherwise addresses alias.
module apb_mem_slave_p #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic             PCLK,
    input  logic             PRESET,
    apb_mem_slave_p_if.slave bus
);
    localparam int         STRB_W     = DATA_WIDTH / 8;
    localparam int         LANE_SHIFT = $clog2(STRB_W);
    localparam int         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS         = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [3:0]            cnt_r;
    logic [3:0]            cnt_nxt_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    logic [ADDR_WIDTH-1:0] word_s;
    logic [ADDR_WIDTH-1:0] byte_off_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  err_s;
    logic                  complete_s;
    logic                  wr_en_s;

    assign word_s     = bus.PADDR >> LANE_SHIFT;
    assign byte_off_s = bus.PADDR & ADDR_WIDTH'(STRB_W - 1);
    assign idx_s      = word_s[IDX_W-1:0];

`ifdef APB_SLV_ERR_EN
    assign err_s = (word_s >= ADDR_WIDTH'(DEPTH)) || (byte_off_s != {ADDR_WIDTH{1'b0}});
`else
    // Upper word bits and the byte offset are deliberately dropped so accesses alias.
    logic unused_addr_s;
    assign unused_addr_s = ^{word_s, byte_off_s};
    assign err_s         = 1'b0;
`endif

    // Reset is gated in so a transfer caught mid-access never reports completion.
    assign complete_s = !PRESET && (state_r == ST_ACCESS) && bus.PSEL && bus.PENABLE
                        && (cnt_r == 4'd0);
    assign wr_en_s    = complete_s && bus.PWRITE && !err_s;

    // State and wait-counter register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: setup arms the wait counter, access counts it down, PSEL low aborts.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_nxt_s = ST_ACCESS;
                    cnt_nxt_s   = WS;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_ACCESS: begin
                if (!bus.PSEL) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (!bus.PENABLE) begin
                    // A fresh setup without finishing the old transfer restarts the wait.
                    state_nxt_s = ST_ACCESS;
                    cnt_nxt_s   = WS;
                end else if (cnt_r != 4'd0) begin
                    state_nxt_s = ST_ACCESS;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Memory array: cleared on reset, byte-lane writes at the end of a completion cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.PSTRB[b]) begin
                    mem_r[idx_s][8*b +: 8] <= bus.PWDATA[8*b +: 8];
                end
            end
        end
    end

    // Completion-phase outputs; read data is forced to zero outside a clean read completion.
    always_comb begin
        bus.PREADY  = complete_s;
        bus.PSLVERR = complete_s && err_s;
        if (complete_s && !bus.PWRITE && !err_s) begin
            bus.PRDATA = mem_r[idx_s];
        end else begin
            bus.PRDATA = {DATA_WIDTH{1'b0}};
        end
    end
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p: three instances (0, 2 and 3 wait states) share one driven bus,
// each with its own PSEL; results are checked with immediate assertions at each step.
module tb_apb_mem_slave_p;
    logic        PCLK;
    logic        PRESET;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          sel;
    int          vectors;
    int          miscompares;

    logic        ready_s;
    logic [31:0] prdata_s;
    logic        pslverr_s;

    apb_mem_slave_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    apb_mem_slave_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();
    apb_mem_slave_p_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus3 ();

    assign bus0.PSEL = psel && (sel == 0);
    assign bus2.PSEL = psel && (sel == 2);
    assign bus3.PSEL = psel && (sel == 3);
    assign {bus0.PENABLE, bus0.PWRITE, bus0.PADDR, bus0.PWDATA, bus0.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {bus2.PENABLE, bus2.PWRITE, bus2.PADDR, bus2.PWDATA, bus2.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {bus3.PENABLE, bus3.PWRITE, bus3.PADDR, bus3.PWDATA, bus3.PSTRB} = {penable, pwrite, paddr, pwdata, pstrb};

    assign ready_s   = (sel == 0) ? bus0.PREADY  : (sel == 2) ? bus2.PREADY  : bus3.PREADY;
    assign prdata_s  = (sel == 0) ? bus0.PRDATA  : (sel == 2) ? bus2.PRDATA  : bus3.PRDATA;
    assign pslverr_s = (sel == 0) ? bus0.PSLVERR : (sel == 2) ? bus2.PSLVERR : bus3.PSLVERR;

    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128), .WAIT_STATES(0))
        dut_ws0 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus0));
    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128), .WAIT_STATES(2))
        dut_ws2 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus2));
    apb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(128), .WAIT_STATES(3))
        dut_ws3 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus3));

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns read data, error flag and the cycle (setup = 1) on which PREADY rose.
    task automatic xfer(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] st, output logic [31:0] rd, output logic er, output int cyc);
        logic got;
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
        rd = 32'h0; er = 1'b0; got = 1'b0; cyc = 1;
        @(posedge PCLK); #1;
        penable = 1'b1; cyc = 2;
        for (int k = 0; k < 32 && !got; k++) begin
            @(negedge PCLK);
            if (ready_s) begin
                got = 1'b1; rd = prdata_s; er = pslverr_s;
            end else begin
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        check("ready_seen", {31'd0, got}, 32'd1);
        @(posedge PCLK); #1;
        @(negedge PCLK);
        check("ready_one_cycle", {31'd0, ready_s}, 32'd0);
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        vectors = 0; miscompares = 0; sel = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        @(negedge PCLK);
        check("rst_pready", {31'd0, bus0.PREADY}, 32'd0);
        check("rst_prdata", bus0.PRDATA, 32'h0);
        check("rst_pslverr", {31'd0, bus0.PSLVERR}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Zero wait states: two-cycle write and read.
        xfer(0, 1'b1, 32'h04, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
        check("ws0_wr_cycles", 32'(cyc), 32'd2);
        check("ws0_wr_err", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        check("ws0_rd_cycles", 32'(cyc), 32'd2);
        check("ws0_rd_data", rd, 32'hA5A5A5A5);

        // Reset asserted in the access cycle of a write: no PREADY, write dropped, memory cleared.
        sel = 0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        check("rst_mid_pready", {31'd0, ready_s}, 32'd0);
        @(posedge PCLK); #1;
        psel = 1'b0; penable = 1'b0; PRESET = 1'b0;
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        check("rst_mid_rd10", rd, 32'h0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        check("rst_clears_mem", rd, 32'h0);

        // Byte strobes.
        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF, rd, er, cyc);
        xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        check("strb_0101", rd, 32'h11BB33DD);
        xfer(0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'b0000, rd, er, cyc);
        check("strb0_cycles", 32'(cyc), 32'd2);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        check("strb0_nochange", rd, 32'h11BB33DD);

        // Three wait states: PREADY on the fifth cycle.
        xfer(3, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
        check("ws3_rd_cycles", 32'(cyc), 32'd5);
        check("ws3_rd_data", rd, 32'h0);

        // Two wait states with a master abort.
        xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, rd, er, cyc);
        check("ws2_wr_cycles", 32'(cyc), 32'd4);
        sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(negedge PCLK);
        check("abort_no_ready_a", {31'd0, ready_s}, 32'd0);
        @(posedge PCLK); #1;
        psel = 1'b0;
        @(negedge PCLK);
        check("abort_no_ready_b", {31'd0, ready_s}, 32'd0);
        @(posedge PCLK); #1;
        penable = 1'b0;
        @(negedge PCLK);
        check("abort_no_ready_c", {31'd0, ready_s}, 32'd0);
        @(posedge PCLK); #1;
        xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        check("abort_idle_cycles", 32'(cyc), 32'd4);
        check("abort_mem_kept", rd, 32'h12345678);

`ifdef APB_SLV_ERR_EN
        xfer(0, 1'b1, 32'h200, 32'h00000005, 4'hF, rd, er, cyc);
        check("err_range_wr", {31'd0, er}, 32'd1);
        xfer(0, 1'b1, 32'h06, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        check("err_misalign_wr", {31'd0, er}, 32'd1);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        check("err_mem_kept", rd, 32'h11BB33DD);
        check("err_ok_rd", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
        check("err_no_alias", rd, 32'h0);
        xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, rd, er, cyc);
        check("err_range_rd", {31'd0, er}, 32'd1);
        check("err_range_rd_data", rd, 32'h0);
`else
        xfer(0, 1'b1, 32'h200, 32'h00000005, 4'hF, rd, er, cyc);
        check("alias_wr_err", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h000, 32'h0, 4'h0, rd, er, cyc);
        check("alias_rd", rd, 32'h00000005);
        check("alias_rd_err", {31'd0, er}, 32'd0);
        xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, rd, er, cyc);
        check("offset_ignored", rd, 32'h11BB33DD);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
